iterative_muldiv_unit: RTL and testbench
========================================

ITERATIVE_MULDIV_UNIT -- requirements
Module: iterative_muldiv_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width in bits; legal values are even and >= 8.
REQ-002 Parameter COUNT_WIDTH, default 6, iteration counter width; it SHALL satisfy 2^COUNT_WIDTH > DATA_WIDTH.
REQ-003 Port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: operation request, qualified by ready.
REQ-006 Port opSelect, input, 3 bits: 0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 REM, 6 REMU, 7 reserved.
REQ-007 Port aOperand, input, DATA_WIDTH bits: multiplicand or dividend.
REQ-008 Port bOperand, input, DATA_WIDTH bits: multiplier or divisor.
REQ-009 Port flush, input, 1 bit: abort the operation in flight.
REQ-010 Port resultAck, input, 1 bit: consumer accepts the result.
REQ-011 Port ready, output, 1 bit: unit can accept start.
REQ-012 Port resultValid, output, 1 bit: result and error flag valid.
REQ-013 Port result, output, DATA_WIDTH bits: operation result.
REQ-014 Port error, output, 1 bit: reserved opcode accepted.

Function
REQ-015 The unit SHALL implement a state machine with states IDLE, BUSY and DONE; ready SHALL be 1 only in IDLE, and resultValid SHALL be 1 only in DONE.
REQ-016 Acceptance occurs on an edge with start=1 and ready=1; on that edge opSelect, aOperand and bOperand SHALL be latched, and later input changes SHALL NOT affect the result.
REQ-017 For opcodes 0-6 without a special case, acceptance SHALL enter BUSY and perform one radix-2 step per cycle for DATA_WIDTH cycles; resultValid SHALL rise on the DATA_WIDTH+1-th edge after acceptance.
REQ-018 Multiply SHALL use magnitude shift-add with a 2*DATA_WIDTH-bit product.
REQ-019 MUL SHALL return the low half of the product.
REQ-020 MULH SHALL return the high half of the signed x signed product.
REQ-021 MULHU SHALL return the high half of the unsigned x unsigned product.
REQ-022 Divide SHALL use restoring division on magnitudes.
REQ-023 For signed divide, the quotient sign SHALL be aSign XOR bSign.
REQ-024 For signed remainder, the remainder sign SHALL follow the dividend; quotients truncate toward zero.
REQ-025 Special cases SHALL skip BUSY and enter DONE on the acceptance edge (resultValid one edge after acceptance):
  - divisor zero: DIV/DIVU -> all ones; REM/REMU -> aOperand.
  - signed overflow (aOperand = most-negative, bOperand = all ones): DIV -> most-negative; REM -> 0.
  - opSelect 7: result 0, error=1.
REQ-026 In DONE, result and error SHALL hold stable until an edge with resultAck=1, which returns the unit to IDLE; ready SHALL rise on the cycle after that edge.
REQ-027 A start in BUSY or DONE SHALL be ignored, with no queuing.
REQ-028 A flush=1 edge in BUSY SHALL return the unit to IDLE and discard the result, with no resultValid pulse.
REQ-029 flush in DONE SHALL also return to IDLE.
REQ-030 flush in IDLE SHALL block acceptance on that edge.
REQ-031 flush SHALL have priority over start and resultAck.
REQ-032 resultAck outside DONE SHALL be ignored.
REQ-033 The iteration counter SHALL count from 0 to DATA_WIDTH-1; it SHALL NOT wrap or overrun, and BUSY SHALL exit exactly on terminal count.

Reset
REQ-034 While reset=0, asynchronously: state IDLE, ready=1, resultValid=0, result=0, error=0, internal counter and accumulators zero.
REQ-035 Reset asserted mid-operation SHALL abandon the operation, with no result produced after release.
REQ-036 The first acceptance SHALL be possible on the first rising clk edge with reset=1.

Verification
REQ-037 MUL: DATA_WIDTH=32, MUL a=7, b=-3 (0xFFFFFFFD) -> resultValid 33 edges after acceptance, result 0xFFFFFFEB; hold 5 cycles without resultAck -> value stable.
REQ-038 MULH/MULHU: a=0x80000000, b=2 -> MULH result 0xFFFFFFFF; MULHU result 0x00000001.
REQ-039 Signed divide: DIV a=-7, b=2 -> 0xFFFFFFFD; REM a=-7, b=2 -> 0xFFFFFFFF; DIVU a=0xFFFFFFFE, b=2 -> 0x7FFFFFFF.
REQ-040 Special cases: DIV by 0 -> 0xFFFFFFFF and REMU a=9, b=0 -> 9, each one edge after acceptance; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; opSelect 7 -> error=1, result 0.
REQ-041 Flush and ignored start: flush on cycle 10 of BUSY -> IDLE next edge, no resultValid; start during BUSY ignored; flush and start in the same IDLE cycle -> no acceptance.
REQ-042 Reset mid-operation: reset=0 at cycle 15 of a DIV -> immediate IDLE with outputs zero; after release, MUL 3*4 -> 12 normally.

Source files
------------

// File: rtl/iterative_muldiv_unit.sv
// iterative_muldiv_unit: radix-2 shift-add multiplier and restoring divider, one step per cycle
module iterative_muldiv_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            opSelect,
  input  logic [DATA_WIDTH-1:0] aOperand,
  input  logic [DATA_WIDTH-1:0] bOperand,
  input  logic                  flush,
  input  logic                  resultAck,
  output logic                  ready,
  output logic                  resultValid,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  error
);
  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateType;
  stateType state, nextState;

  logic [2*W-1:0]         acc;
  logic [W-1:0]           bReg;
  logic [2:0]             opReg;
  logic                   negReg;
  logic [COUNT_WIDTH-1:0] count;

  assign ready       = state == IDLE;
  assign resultValid = state == DONE;

  logic accept, lastStep, isMul, isSigned, aSign, bSign, divZero, overflow, special;
  logic [W-1:0] aMag, bMag, specialResult;
  assign accept   = start && ready && !flush;
  assign lastStep = count == COUNT_WIDTH'(W - 1);
  assign isMul    = opSelect <= 3'd2;
  assign isSigned = opSelect == 3'd0 || opSelect == 3'd1 || opSelect == 3'd3 || opSelect == 3'd5;
  assign aSign    = isSigned && aOperand[W-1];
  assign bSign    = isSigned && bOperand[W-1];
  assign aMag     = aSign ? -aOperand : aOperand;
  assign bMag     = bSign ? -bOperand : bOperand;
  assign divZero  = !isMul && opSelect != 3'd7 && bOperand == '0;
  assign overflow = (opSelect == 3'd3 || opSelect == 3'd5) && aOperand == MIN_VAL && &bOperand;
  assign special  = opSelect == 3'd7 || divZero || overflow;
  assign specialResult = opSelect == 3'd7 ? '0
                       : divZero ? ((opSelect == 3'd3 || opSelect == 3'd4) ? '1 : aOperand)
                       : (opSelect == 3'd3 ? MIN_VAL : '0);

  // One iteration: multiply adds the multiplicand into the high half then shifts right;
  // divide shifts the next dividend bit into the remainder and subtracts when it fits.
  logic [W:0]     mulSum, shifted;
  logic           fits;
  logic [W-1:0]   divRem, qFix, rFix, finalResult;
  logic [2*W-1:0] accNext, prodFix;
  assign mulSum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, bReg} : '0);
  assign shifted = acc[2*W-1:W-1];
  assign fits    = shifted >= {1'b0, bReg};
  assign divRem  = fits ? W'(shifted - {1'b0, bReg}) : shifted[W-1:0];
  assign accNext = opReg <= 3'd2 ? {mulSum, acc[W-1:1]} : {divRem, acc[W-2:0], fits};
  assign prodFix = negReg ? -accNext : accNext;
  assign qFix    = negReg ? -accNext[W-1:0] : accNext[W-1:0];
  assign rFix    = negReg ? -accNext[2*W-1:W] : accNext[2*W-1:W];
  assign finalResult = opReg == 3'd0 ? prodFix[W-1:0]
                     : opReg <= 3'd2 ? prodFix[2*W-1:W]
                     : opReg <= 3'd4 ? qFix : rFix;

  // State register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nextState;

  // Next state: flush wins over start and resultAck; specials go straight to DONE
  always_comb begin
    nextState = state;
    if (state == IDLE) nextState = accept ? (special ? DONE : BUSY) : IDLE;
    else if (state == BUSY) nextState = flush ? IDLE : lastStep ? DONE : BUSY;
    else nextState = (flush || resultAck) ? IDLE : DONE;
  end

  // Datapath: latch magnitudes on acceptance, iterate in BUSY, capture result on the last step
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc    <= '0;
      bReg   <= '0;
      opReg  <= '0;
      negReg <= 1'b0;
      count  <= '0;
      result <= '0;
      error  <= 1'b0;
    end else if (accept) begin
      acc    <= {{W{1'b0}}, aMag};
      bReg   <= bMag;
      opReg  <= opSelect;
      negReg <= opSelect == 3'd5 ? aSign : aSign ^ bSign;
      count  <= '0;
      error  <= opSelect == 3'd7;
      if (special) result <= specialResult;
    end else if (state == BUSY && !flush) begin
      acc   <= accNext;
      count <= lastStep ? count : count + COUNT_WIDTH'(1);
      if (lastStep) result <= finalResult;
    end
endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// tb_iterative_muldiv_unit: directed vectors with a scoreboard-driven monitor
module tb_iterative_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0, resultAck = 1'b0;
  logic [2:0] opSelect = '0;
  logic [W-1:0] aOperand = '0, bOperand = '0;
  logic ready, resultValid, error;
  logic [W-1:0] result;

  int tests = 0, fails = 0, cyc = 0;

  typedef struct { string name; logic [W-1:0] res; logic err; int lat; int acc; } expT;
  typedef struct { string name; logic rdy; logic vld; logic chk; logic [W-1:0] res; logic err; } stsT;
  expT expQ[$];
  stsT stsQ[$];
  expT cur;
  stsT s;
  logic prevValid = 1'b0;

  iterative_muldiv_unit #(.DATA_WIDTH(W), .COUNT_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .start(start), .opSelect(opSelect),
    .aOperand(aOperand), .bOperand(bOperand), .flush(flush), .resultAck(resultAck),
    .ready(ready), .resultValid(resultValid), .result(result), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  // Monitor: status probes, then result/latency on valid rise, then stability on acknowledge
  always @(negedge clk) begin
    while (stsQ.size() > 0) begin
      s = stsQ.pop_front();
      check({s.name, "_ready"}, ready, s.rdy);
      check({s.name, "_valid"}, resultValid, s.vld);
      if (s.chk) begin
        check({s.name, "_result"}, result, s.res);
        check({s.name, "_error"}, error, s.err);
      end
    end
    if (resultValid && !prevValid) begin
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got result %h, expected no result", result);
      end else begin
        cur = expQ.pop_front();
        check({cur.name, "_result"}, result, cur.res);
        check({cur.name, "_error"}, error, cur.err);
        check({cur.name, "_latency"}, W'(cyc - cur.acc + 1), W'(cur.lat));
      end
    end
    if (resultValid && resultAck) check({cur.name, "_hold"}, result, cur.res);
    prevValid = resultValid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sts(input string n, input logic r, input logic v, input logic c,
                     input logic [W-1:0] res, input logic e);
    stsQ.push_back('{n, r, v, c, res, e});
  endtask

  task automatic issue(input string n, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res, input logic e,
                       input int lat, input bit push);
    opSelect = op;
    aOperand = a;
    bOperand = b;
    start = 1'b1;
    if (push) expQ.push_back('{n, res, e, lat, cyc + 1});
    tick();
    start = 1'b0;
    opSelect = 3'($urandom);
    aOperand = $urandom;
    bOperand = $urandom;
  endtask

  task automatic complete(input string n, input int hold);
    for (int i = 0; i < 100; i++) begin
      if (resultValid) break;
      tick();
    end
    sts({n, "_wait"}, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    repeat (hold) tick();
    resultAck = 1'b1;
    tick();
    resultAck = 1'b0;
    sts({n, "_acked"}, 1'b1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic op(input string n, input logic [2:0] o, input logic [W-1:0] a,
                    input logic [W-1:0] b, input logic [W-1:0] res, input logic e,
                    input int lat, input int hold);
    issue(n, o, a, b, res, e, lat, 1'b1);
    complete(n, hold);
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (3) tick();
    sts("reset_state", 1'b1, 1'b0, 1'b1, '0, 1'b0);
    tick();
    reset = 1'b1;
    op("mul_7_m3",      3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33, 5);
    op("mulh_min_2",    3'd1, 32'h80000000, 32'd2,        32'hFFFFFFFF, 1'b0, 33, 1);
    op("mulhu_min_2",   3'd2, 32'h80000000, 32'd2,        32'h00000001, 1'b0, 33, 0);
    op("mulh_m1_m1",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33, 0);
    op("mulhu_m1_m1",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33, 0);
    op("mul_ffff_ffff", 3'd0, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 1'b0, 33, 0);
    op("div_m7_2",      3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33, 0);
    op("rem_m7_2",      3'd5, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33, 0);
    op("divu_fffe_2",   3'd4, 32'hFFFFFFFE, 32'd2,        32'h7FFFFFFF, 1'b0, 33, 0);
    op("div_7_m2",      3'd3, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33, 0);
    op("rem_7_m2",      3'd5, 32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 0);
    op("divu_100_7",    3'd4, 32'd100,      32'd7,        32'd14,       1'b0, 33, 0);
    op("remu_100_7",    3'd6, 32'd100,      32'd7,        32'd2,        1'b0, 33, 0);
    op("div_by_zero",   3'd3, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 1, 2);
    op("remu_by_zero",  3'd6, 32'd9,        32'd0,        32'd9,        1'b0, 1, 0);
    op("div_overflow",  3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1, 0);
    op("rem_overflow",  3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1, 0);
    op("reserved_op",   3'd7, 32'd3,        32'd4,        32'h00000000, 1'b1, 1, 1);
    op("after_error",   3'd0, 32'd6,        32'd7,        32'd42,       1'b0, 33, 0);
    issue("mul_busy_start", 3'd0, 32'd3, 32'd5, 32'd15, 1'b0, 33, 1'b1);
    repeat (3) tick();
    opSelect = 3'd7;
    aOperand = 32'd1;
    bOperand = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    complete("mul_busy_start", 1);
    issue("mul_flush", 3'd0, 32'd5, 32'd5, '0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      start = i == 4;
      tick();
    end
    start = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sts("flush_busy", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    repeat (40) tick();
    sts("flush_no_valid", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    opSelect = 3'd7;
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    sts("flush_blocks_accept", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    repeat (3) tick();
    issue("flush_done_div0", 3'd4, 32'd8, 32'd0, 32'hFFFFFFFF, 1'b0, 1, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sts("flush_done", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    tick();
    issue("div_reset", 3'd3, 32'd100, 32'd7, '0, 1'b0, 0, 1'b0);
    repeat (14) tick();
    reset = 1'b0;
    #1;
    sts("reset_mid", 1'b1, 1'b0, 1'b1, '0, 1'b0);
    tick();
    reset = 1'b1;
    op("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12, 1'b0, 33, 1);
    repeat (40) tick();
    sts("final_idle", 1'b1, 1'b0, 1'b0, '0, 1'b0);
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1);
  end
endmodule
